// File: rtl/sr_lock_pkg.sv
// sr_lock_pkg
// Shared definitions for the round-robin lock arbiter.
//   DEF_N / DEF_MAX_HOLD : default requester count and watchdog limit
//   MAX_N                : largest supported requester count
//   lock_state_t         : arbiter FSM states
//   onehot()             : index to one-hot vector (MAX_N bits wide)
package sr_lock_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;
  localparam int MAX_N        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    GAP  = 2'd2
  } lock_state_t;

  // Indices at or beyond n yield an all-zero vector rather than a stray bit.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n) v = MAX_N'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotating-priority picker: finds the first set request bit
// starting at ptr and searching upward, wrapping modulo N.
//   req   : request vector
//   ptr   : position with highest priority this cycle
//   valid : at least one request is set
//   idx   : index of the winning request
module rr_pick
  import sr_lock_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int OW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic          valid,
  output logic [OW-1:0] idx
);

  logic [OW:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  // The wrap is done by subtraction because N need not be a power of two.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (OW+1)'(i);
      if (cand >= (OW+1)'(N)) cand = cand - (OW+1)'(N);
      if (req[cand[OW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/sr_lock_arbiter.sv
// sr_lock_arbiter
// Round-robin mutual-exclusion arbiter for one shared resource. Ownership is
// a set/reset lock flag; a hold-time watchdog revokes long grants.
//   clk     : rising-edge clock
//   reset   : synchronous active-low reset
//   req     : per-requester request level
//   rel     : per-requester release pulse (only the owner's is honoured)
//   gnt     : registered one-hot grant, zero when nobody owns the lock
//   busy    : lock flag, high exactly while gnt is non-zero
//   owner   : current owner index, holds the last owner while idle
//   timeout : one-cycle pulse when the watchdog revokes a grant
module sr_lock_arbiter
  import sr_lock_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int OW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  rel,
  output logic [N-1:0]  gnt,
  output logic          busy,
  output logic [OW-1:0] owner,
  output logic          timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  lock_state_t   state, state_nx;
  logic [OW-1:0] ptr, ptr_nx, owner_nx;
  logic [N-1:0]  gnt_nx;
  logic [CW-1:0] hold_cnt, hold_cnt_nx;
  logic          timeout_nx;
  logic          lock_set, lock_clr;
  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic          rel_own, req_own, wd_hit;

  rr_pick #(.N(N), .OW(OW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign rel_own = rel[owner];
  assign req_own = req[owner];
  assign wd_hit  = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));

  // Next-state logic. The lock flag is set only from IDLE and cleared only
  // from HELD, so set and clear can never coincide.
  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    owner_nx    = owner;
    ptr_nx      = ptr;
    hold_cnt_nx = hold_cnt;
    timeout_nx  = 1'b0;
    lock_set    = 1'b0;
    lock_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_nx      = N'(onehot(32'(pick_idx), N));
          owner_nx    = pick_idx;
          ptr_nx      = (pick_idx == OW'(N - 1)) ? '0 : pick_idx + OW'(1);
          hold_cnt_nx = '0;
          lock_set    = 1'b1;
          state_nx    = HELD;
        end
      end
      HELD: begin
        if (hold_cnt != CW'(MAX_HOLD)) hold_cnt_nx = hold_cnt + CW'(1);
        if (rel_own || !req_own || wd_hit) begin
          gnt_nx     = '0;
          lock_clr   = 1'b1;
          // A release in the same cycle takes credit for the exit.
          timeout_nx = wd_hit && !rel_own;
          state_nx   = GAP;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, grant, owner, pointer, watchdog counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_cnt_nx;
      timeout  <= timeout_nx;
    end
  end

  // Lock flag: plain synchronous set/reset register.
  always_ff @(posedge clk) begin
    if (!reset)        busy <= 1'b0;
    else if (lock_set) busy <= 1'b1;
    else if (lock_clr) busy <= 1'b0;
  end

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// tb_sr_lock_arbiter
// Scoreboard bench for sr_lock_arbiter (N=4, MAX_HOLD=8). The stimulus
// process pushes the grant it expects (vector, owner, hold length, timeout
// on exit, idle gap before it); the monitor pops one entry per grant.
module tb_sr_lock_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] rel;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    int         hold;
    logic       to;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  exp_t mon_cur;
  bit   mon_active = 1'b0;
  int   mon_hold = 0;
  int   mon_zeros = -1;

  sr_lock_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // One comparison; both processes call it at different times.
  task automatic reportCheck(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
    req = r;
    rel = l;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic eb,
                             input logic [1:0] eo, input logic et);
    reportCheck(name, {24'd0, gnt, busy, owner, timeout}, {24'd0, eg, eb, eo, et});
  endtask

  task automatic pushExp(input logic [3:0] g, input logic [1:0] o, input int h,
                         input logic t, input int gp);
    exp_t e;
    e.gnt = g; e.owner = o; e.hold = h; e.to = t; e.gap = gp;
    exp_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge and tracks grants.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      reportCheck("lock_sr_exclusive", 32'(dut.lock_set & dut.lock_clr), 32'd0);
      if (!reset) begin
        reportCheck("reset_outputs", {24'd0, gnt, busy, owner, timeout}, 32'd0);
        mon_active = 1'b0;
        mon_zeros  = -1;
      end else begin
        reportCheck("busy_vs_gnt", 32'(busy), 32'(|gnt));
        if (!mon_active && gnt != 4'd0) begin
          if (exp_q.size() == 0) begin
            reportCheck("unexpected_grant", 32'(gnt), 32'd0);
            mon_cur = '{gnt: 4'd0, owner: 2'd0, hold: -1, to: 1'b0, gap: -1};
          end else begin
            mon_cur = exp_q.pop_front();
            reportCheck("grant_vec", 32'(gnt), 32'(mon_cur.gnt));
            reportCheck("grant_owner", 32'(owner), 32'(mon_cur.owner));
            if (mon_cur.gap >= 0) reportCheck("grant_gap", mon_zeros, mon_cur.gap);
          end
          reportCheck("timeout_at_grant", 32'(timeout), 32'd0);
          mon_active = 1'b1;
          mon_hold   = 1;
        end else if (mon_active && gnt != 4'd0) begin
          mon_hold++;
          reportCheck("grant_stable", 32'(gnt), 32'(mon_cur.gnt));
          reportCheck("timeout_while_held", 32'(timeout), 32'd0);
        end else if (mon_active) begin
          if (mon_cur.hold >= 0) reportCheck("hold_len", mon_hold, mon_cur.hold);
          reportCheck("timeout_on_drop", 32'(timeout), 32'(mon_cur.to));
          mon_active = 1'b0;
          mon_zeros  = 1;
        end else begin
          reportCheck("timeout_idle", 32'(timeout), 32'd0);
          if (mon_zeros >= 0) mon_zeros++;
        end
      end
    end
  end

  // Stimulus. Inputs change on falling edges; comments give the cycle
  // number counted in rising edges since time zero.
  initial begin
    logic [3:0] r;
    reset = 1'b0;
    applyStimulus(4'b1111, 4'b0000);
    @(negedge clk);                                   // cycle 1
    checkOutput("reset_c1", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);                                   // cycle 2
    checkOutput("reset_c2", 4'b0000, 1'b0, 2'd0, 1'b0);

    // Round-robin: everyone requests, each owner releases after one cycle.
    pushExp(4'b0001, 2'd0, 2, 1'b0, -1);
    pushExp(4'b0010, 2'd1, 2, 1'b0, 2);
    pushExp(4'b0100, 2'd2, 2, 1'b0, 2);
    pushExp(4'b1000, 2'd3, 2, 1'b0, 2);
    pushExp(4'b0001, 2'd0, 2, 1'b0, 2);
    reset = 1'b1;
    @(negedge clk);                                   // cycle 3: first grant
    checkOutput("first_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      r = 4'b0001 << (j % 4);
      @(negedge clk); applyStimulus(4'b1111, r);
      @(negedge clk); applyStimulus((j == 4) ? 4'b0000 : 4'b1111, 4'b0000);
      @(negedge clk);
      @(negedge clk);
    end                                               // now cycle 23

    // Single requester: release 3 cycles after grant, then regrant.
    pushExp(4'b0100, 2'd2, 4, 1'b0, 3);
    pushExp(4'b0100, 2'd2, 1, 1'b0, 2);
    applyStimulus(4'b0100, 4'b0000);                  // grant at 24
    repeat (4) @(negedge clk);                        // cycle 27
    applyStimulus(4'b0100, 4'b0100);
    @(negedge clk);                                   // cycle 28
    applyStimulus(4'b0100, 4'b0000);
    repeat (2) @(negedge clk);                        // cycle 30: regrant
    checkOutput("regrant", 4'b0100, 1'b1, 2'd2, 1'b0);

    // Watchdog: requester 1 never releases; then release meets expiry.
    pushExp(4'b0010, 2'd1, 8, 1'b1, 2);
    pushExp(4'b0010, 2'd1, 8, 1'b0, 2);
    applyStimulus(4'b0010, 4'b0000);                  // drop req[2]
    repeat (14) @(negedge clk);                       // cycle 44
    applyStimulus(4'b0010, 4'b1000);                  // non-owner release
    @(negedge clk);                                   // cycle 45
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("nonowner_rel_ignored", 4'b0010, 1'b1, 2'd1, 1'b0);
    repeat (5) @(negedge clk);                        // cycle 50, count 7
    applyStimulus(4'b0010, 4'b0010);
    @(negedge clk);                                   // cycle 51
    pushExp(4'b0100, 2'd2, -1, 1'b0, 2);
    applyStimulus(4'b0100, 4'b0000);

    // Mid-grant reset while requester 2 owns the lock.
    repeat (3) @(negedge clk);                        // cycle 54
    checkOutput("owner2_before_reset", 4'b0100, 1'b1, 2'd2, 1'b0);
    reset = 1'b0;
    @(negedge clk);                                   // cycle 55
    checkOutput("mid_grant_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);                                   // cycle 56
    // Pointer back at 0 means requester 2 beats requester 3.
    pushExp(4'b0100, 2'd2, 1, 1'b0, -1);
    pushExp(4'b1000, 2'd3, 1, 1'b0, 2);
    reset = 1'b1;
    applyStimulus(4'b1100, 4'b0000);
    @(negedge clk);                                   // cycle 57
    applyStimulus(4'b1100, 4'b0100);
    @(negedge clk);                                   // cycle 58
    applyStimulus(4'b1100, 4'b0000);
    repeat (2) @(negedge clk);                        // cycle 60
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) @(negedge clk);                        // cycle 62
    checkOutput("idle_holds_owner", 4'b0000, 1'b0, 2'd3, 1'b0);
    repeat (4) @(negedge clk);
    reportCheck("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    errors++;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
